fp_result_packer: RTL and testbench

//  Output-side converter for the single-path adder/conversion datapath. Takes internal-format results
//  {exception[1:0], sign, exponent, mantissa-without-hidden-bit} and emits IEEE-754 words, or raw

---
 rtl/fp_result_packer.sv | 151 +++++++++++++++
 tb/tb_fp_result_packer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_packer.sv
// rtl/fp_result_packer.sv - internal-format result to IEEE-754/integer word packer
//
// Converts {exception, sign, exponent, mantissa} results into IEEE-754 words,
// or passes FP->int results through unchanged. Two-stage valid/ready pipeline
// with full backpressure, plus saturating exception counters for status readout.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_int                1 = in_number carries an integer result
//   in_number             internal-format result
//   out_valid/out_ready   output handshake
//   out_word, out_flags   packed word and {nan, inf, zero, ovf}
//   clr_stats             synchronous clear of all counters
//   cnt_nan/inf/ovf       saturating counters of delivered exception words
module fp_result_packer #(
   parameter int size_mantissa        = 24,
   parameter int size_exponent        = 8,
   parameter int size_exception_field = 2,
   parameter int size_integer         = 32,
   parameter int size_counter_stat    = 16,
   parameter int size                 = size_mantissa + size_exponent + size_exception_field
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_int,
   input  logic [size-1:0]              in_number,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [size_integer-1:0]      out_word,
   output logic [3:0]                   out_flags,
   input  logic                         clr_stats,
   output logic [size_counter_stat-1:0] cnt_nan,
   output logic [size_counter_stat-1:0] cnt_inf,
   output logic [size_counter_stat-1:0] cnt_ovf
);

   localparam int size_word = size_exponent + size_mantissa;

   localparam logic [size_exception_field-1:0] exc_zero   = size_exception_field'(0);
   localparam logic [size_exception_field-1:0] exc_normal = size_exception_field'(1);
   localparam logic [size_exception_field-1:0] exc_inf    = size_exception_field'(2);

   // flag bit positions inside {nan, inf, zero, ovf}
   localparam int flag_nan = 3;
   localparam int flag_inf = 2;
   localparam int flag_ovf = 0;

   logic [size_exception_field-1:0] exc;
   logic                            sgn;
   logic [size_exponent-1:0]        expo;
   logic [size_integer-1:0]         dec_word;
   logic [3:0]                      dec_flags;

   logic                            s1_valid;
   logic [size_integer-1:0]         s1_word;
   logic [3:0]                      s1_flags;
   logic                            s2_valid;
   logic                            s1_load;
   logic                            s2_load;
   logic                            out_hs;

   assign exc  = in_number[size-1 -: size_exception_field];
   assign sgn  = in_number[size_word-1];
   assign expo = in_number[size_mantissa-1 +: size_exponent];

   always_comb begin
      dec_word  = '0;
      dec_flags = 4'b0000;
      if (in_int) begin
         dec_word = in_number[size_integer-1:0];
      end else begin
         case (exc)
            // zero is always emitted as +0 to match the adder's zero convention
            exc_zero: begin
               dec_flags = 4'b0010;
            end
            exc_normal: begin
               if (&expo) begin
                  // exponent overflowed into the reserved code: report as infinity
                  dec_word  = {sgn, {size_exponent{1'b1}}, {(size_mantissa-1){1'b0}}};
                  dec_flags = 4'b0101;
               end else begin
                  dec_word = in_number[size_word-1:0];
               end
            end
            exc_inf: begin
               dec_word  = {sgn, {size_exponent{1'b1}}, {(size_mantissa-1){1'b0}}};
               dec_flags = 4'b0100;
            end
            default: begin
               // canonical quiet NaN, payload discarded
               dec_word  = {sgn, {size_exponent{1'b1}}, 1'b1, {(size_mantissa-2){1'b0}}};
               dec_flags = 4'b1000;
            end
         endcase
      end
   end

   // each stage refills when empty or when its contents move on this cycle
   assign s2_load   = ~s2_valid | out_ready;
   assign s1_load   = ~s1_valid | s2_load;
   assign in_ready  = s1_load;
   assign out_valid = s2_valid;
   assign out_hs    = s2_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_word   <= '0;
         s1_flags  <= 4'b0000;
         s2_valid  <= 1'b0;
         out_word  <= '0;
         out_flags <= 4'b0000;
      end else begin
         if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_word  <= dec_word;
               s1_flags <= dec_flags;
            end
         end
         if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               out_word  <= s1_word;
               out_flags <= s1_flags;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_nan <= '0;
         cnt_inf <= '0;
         cnt_ovf <= '0;
      end else if (clr_stats) begin
         cnt_nan <= '0;
         cnt_inf <= '0;
         cnt_ovf <= '0;
      end else if (out_hs) begin
         if (out_flags[flag_nan] && !(&cnt_nan)) cnt_nan <= cnt_nan + 1'b1;
         if (out_flags[flag_inf] && !(&cnt_inf)) cnt_inf <= cnt_inf + 1'b1;
         if (out_flags[flag_ovf] && !(&cnt_ovf)) cnt_ovf <= cnt_ovf + 1'b1;
      end
   end

endmodule

// File: tb/tb_fp_result_packer.sv
// tb/tb_fp_result_packer.sv - randomized scoreboard bench for fp_result_packer
module tb_fp_result_packer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_int;
   logic [33:0] in_number;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [3:0]  out_flags;
   logic        clr_stats;
   logic [15:0] cnt_nan;
   logic [15:0] cnt_inf;
   logic [15:0] cnt_ovf;

   fp_result_packer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_int    (in_int),
      .in_number (in_number),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_flags (out_flags),
      .clr_stats (clr_stats),
      .cnt_nan   (cnt_nan),
      .cnt_inf   (cnt_inf),
      .cnt_ovf   (cnt_ovf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [35:0] exp_q[$];
   logic [35:0] out_log[$];
   int          out_cyc[$];
   int          m_nan, m_inf, m_ovf;
   logic        hold_pending;
   logic [35:0] hold_val;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {flags[3:0], word[31:0]} from the conversion rules
   function automatic logic [35:0] ref_model(input logic is_int, input logic [33:0] n);
      int   exc;
      int   e;
      logic s;
      exc = int'(n[33:32]);
      e   = int'(n[30:23]);
      s   = n[31];
      if (is_int) return {4'b0000, n[31:0]};
      if (exc == 0) return {4'b0010, 32'h0000_0000};
      if (exc == 1) begin
         if (e == 255) return {4'b0101, s, 31'h7F80_0000};
         return {4'b0000, n[31:0]};
      end
      if (exc == 2) return {4'b0100, s, 31'h7F80_0000};
      return {4'b1000, s, 31'h7FC0_0000};
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   // one clock cycle: drive, sample, score, advance the model past the next edge
   task automatic cycle(input logic v, input logic is_int, input logic [33:0] num,
                        input logic ordy, input logic clr);
      int occ;
      logic [35:0] e;
      @(negedge clk);
      in_valid  = v;
      in_int    = is_int;
      in_number = num;
      out_ready = ordy;
      clr_stats = clr;
      #1;
      cyc++;
      check("cnt_nan", 64'(cnt_nan), 64'(m_nan));
      check("cnt_inf", 64'(cnt_inf), 64'(m_inf));
      check("cnt_ovf", 64'(cnt_ovf), 64'(m_ovf));
      occ = exp_q.size();
      check("in_ready", 64'(in_ready), 64'((occ < 2) || ordy));
      if (hold_pending) begin
         check("stall_valid", 64'(out_valid), 64'(1));
         check("stall_word", 64'({out_flags, out_word}), 64'(hold_val));
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 64'(1), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("out_word", 64'({out_flags, out_word}), 64'(e));
         end
         out_log.push_back({out_flags, out_word});
         out_cyc.push_back(cyc);
      end
      if (clr) begin
         m_nan = 0; m_inf = 0; m_ovf = 0;
      end else if (out_valid && out_ready) begin
         if (out_flags[3]) m_nan = sat_inc(m_nan);
         if (out_flags[2]) m_inf = sat_inc(m_inf);
         if (out_flags[0]) m_ovf = sat_inc(m_ovf);
      end
      hold_pending = out_valid && !out_ready;
      hold_val     = {out_flags, out_word};
      if (in_valid && in_ready) exp_q.push_back(ref_model(is_int, num));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clr_stats = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_word", 64'({out_flags, out_word}), 64'(0));
      check("rst_cnts", 64'({cnt_nan, cnt_inf, cnt_ovf}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      exp_q.delete();
      out_log.delete();
      out_cyc.delete();
      m_nan = 0; m_inf = 0; m_ovf = 0;
      hold_pending = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 34'h0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [33:0] num;
      logic        v, r, it, c;
      logic [7:0]  ex;
      rst_n = 1'b0; in_valid = 1'b0; in_int = 1'b0; in_number = '0;
      out_ready = 1'b0; clr_stats = 1'b0;
      m_nan = 0; m_inf = 0; m_ovf = 0; hold_pending = 1'b0; hold_val = '0;
      repeat (2) @(negedge clk);
      do_reset();

      // 1: plain normal value, two-cycle latency
      cycle(1'b1, 1'b0, 34'h1_3F80_0000, 1'b1, 1'b0);
      check("t1_lat0", 64'(out_valid), 64'(0));
      cycle(1'b0, 1'b0, 34'h0, 1'b1, 1'b0);
      check("t1_lat1", 64'(out_valid), 64'(0));
      cycle(1'b0, 1'b0, 34'h0, 1'b1, 1'b0);
      check("t1_valid", 64'(out_valid), 64'(1));
      check("t1_word", 64'({out_flags, out_word}), 64'({4'b0000, 32'h3F80_0000}));
      idle(2);

      // 2: NaN, infinity, zero with payload
      do_reset();
      cycle(1'b1, 1'b0, 34'h3_8123_4567, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 34'h2_0012_3456, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 34'h0_8ABC_DEF1, 1'b1, 1'b0);
      idle(3);
      check("t2_count", 64'(out_log.size()), 64'(3));
      if (out_log.size() == 3) begin
         check("t2_nan",  64'(out_log[0]), 64'({4'b1000, 32'hFFC0_0000}));
         check("t2_inf",  64'(out_log[1]), 64'({4'b0100, 32'h7F80_0000}));
         check("t2_zero", 64'(out_log[2]), 64'({4'b0010, 32'h0000_0000}));
      end
      check("t2_cnt_nan", 64'(cnt_nan), 64'(1));
      check("t2_cnt_inf", 64'(cnt_inf), 64'(1));

      // 3: overflow to infinity, integer passthrough
      do_reset();
      cycle(1'b1, 1'b0, 34'h1_7F80_0123, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 34'h1_FFFF_FFFE, 1'b1, 1'b0);
      idle(3);
      check("t3_count", 64'(out_log.size()), 64'(2));
      if (out_log.size() == 2) begin
         check("t3_ovf", 64'(out_log[0]), 64'({4'b0101, 32'h7F80_0000}));
         check("t3_int", 64'(out_log[1]), 64'({4'b0000, 32'hFFFF_FFFE}));
      end
      check("t3_cnt_ovf", 64'(cnt_ovf), 64'(1));
      check("t3_cnt_inf", 64'(cnt_inf), 64'(1));

      // 4: backpressure with three words
      do_reset();
      cycle(1'b1, 1'b1, 34'h0_0000_000A, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 34'h0_0000_000B, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 34'h0_0000_000C, 1'b0, 1'b0);
      check("t4_full", 64'(in_ready), 64'(0));
      cycle(1'b1, 1'b1, 34'h0_0000_000C, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 34'h0_0000_000C, 1'b0, 1'b0);
      check("t4_hold_a", 64'(out_word), 64'(32'hA));
      cycle(1'b1, 1'b1, 34'h0_0000_000C, 1'b1, 1'b0);
      idle(4);
      check("t4_count", 64'(out_log.size()), 64'(3));
      if (out_log.size() == 3) begin
         check("t4_a", 64'(out_log[0][31:0]), 64'(32'hA));
         check("t4_b", 64'(out_log[1][31:0]), 64'(32'hB));
         check("t4_c", 64'(out_log[2][31:0]), 64'(32'hC));
         check("t4_gap_ab", 64'(out_cyc[1] - out_cyc[0]), 64'(1));
         check("t4_gap_bc", 64'(out_cyc[2] - out_cyc[1]), 64'(1));
      end

      // randomized traffic against the scoreboard
      for (int i = 0; i < 2000; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 9) < 7);
         it = ($urandom_range(0, 4) == 0);
         c  = ($urandom_range(0, 49) == 0);
         ex = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         num = {2'($urandom), 1'($urandom), ex, 23'($urandom)};
         cycle(v, it, num, r, c);
      end
      idle(4);
      check("rand_drained", 64'(exp_q.size()), 64'(0));

      // 5: NaN counter saturation, then clear against a simultaneous NaN handshake
      do_reset();
      for (int i = 0; i < 65540; i++) cycle(1'b1, 1'b0, 34'h3_0000_0000, 1'b1, 1'b0);
      check("t5_sat", 64'(cnt_nan), 64'(16'hFFFF));
      check("t5_hs_live", 64'(out_valid && out_ready), 64'(1));
      cycle(1'b1, 1'b0, 34'h3_0000_0000, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 34'h3_0000_0000, 1'b0, 1'b0);
      check("t5_clr", 64'(cnt_nan), 64'(0));

      // 6: reset with both stages full
      cycle(1'b1, 1'b0, 34'h3_0000_0000, 1'b0, 1'b0);
      check("t6_full", 64'(in_ready), 64'(0));
      do_reset();
      idle(3);
      check("t6_no_out", 64'(out_log.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
